// File: rtl/dma_rd_pkg.sv
// Shared types for the DMA read tag pool: pool geometry, release FSM states, per-tag entry.
// Optional head-tag completion timeout is enabled with DMA_RD_TIMEOUT_EN (see dma_rd_tag_scheduler).
package dma_rd_pkg;

  localparam int TAG_NUM = 32;
  localparam int TAG_W   = 5;
  localparam int LEN_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY,
    FREE
  } rel_state_t;

  typedef struct packed {
    logic             valid;
    logic             cmpl;
    logic             last;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] rcv;
  } tag_entry_t;

endpackage

// File: rtl/dma_tag_table.sv
// Per-tag register array: alloc write, completion DW accumulate, free, async head read.
// Writes land on the next clk edge; head read and cpl_err are combinational. No backpressure.
module dma_tag_table
  import dma_rd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_idx,
  input  logic [LEN_W-1:0] alloc_len,
  input  logic             alloc_last,
  input  logic             cpl_en,
  input  logic [TAG_W-1:0] cpl_idx,
  input  logic [LEN_W-1:0] cpl_dw,
  output logic             cpl_err,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_idx,
  input  logic             force_cmpl,
  input  logic [TAG_W-1:0] head_idx,
  output logic             head_valid,
  output logic             head_cmpl,
  output logic             head_last,
  output logic [LEN_W-1:0] head_len
);

  tag_entry_t       tbl [TAG_NUM];
  logic [LEN_W:0]   cpl_sum;
  logic             cpl_live;

  always_comb begin
    cpl_live   = tbl[cpl_idx].valid & ~tbl[cpl_idx].cmpl;
    cpl_sum    = {1'b0, tbl[cpl_idx].rcv} + {1'b0, cpl_dw};
    cpl_err    = cpl_en & (~cpl_live | (cpl_sum > {1'b0, tbl[cpl_idx].len}));
    head_valid = tbl[head_idx].valid;
    head_cmpl  = tbl[head_idx].cmpl;
    head_last  = tbl[head_idx].last;
    head_len   = tbl[head_idx].len;
  end

  // Later statements win: an alloc in the same cycle as a stray cpl to that tag overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAG_NUM; i++) tbl[i] <= '0;
    end else begin
      if (cpl_en && cpl_live) begin
        tbl[cpl_idx].rcv  <= cpl_sum[LEN_W-1:0];
        tbl[cpl_idx].cmpl <= (cpl_sum >= {1'b0, tbl[cpl_idx].len});
      end
      if (force_cmpl) tbl[head_idx].cmpl <= 1'b1;
      if (free_en) tbl[free_idx].valid <= 1'b0;
      if (alloc_en) begin
        tbl[alloc_idx] <= '{valid: 1'b1, cmpl: 1'b0, last: alloc_last,
                            len: alloc_len, rcv: '0};
      end
    end
  end

endmodule

// File: rtl/dma_rd_tag_scheduler.sv
// Circular 32-tag DMA read pool; releases completed tags in allocation order to the drain engine.
// alloc_ack 1 cycle after request; tag_rx_req 2 cycles after final cpl. Full pool holds alloc_ack low.
// DMA_RD_TIMEOUT_EN adds a head-tag timeout with sticky err_timeout output.
module dma_rd_tag_scheduler
  import dma_rd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  input  logic [LEN_W-1:0] alloc_len,
  input  logic             alloc_last,
  output logic             alloc_ack,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cpl_valid,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic [LEN_W-1:0] cpl_dw,
  output logic             tag_rx_req,
  input  logic             tag_rx_ack,
  output logic             tag_rx_last,
  output logic [TAG_W-1:0] tag_rx_number,
  output logic [LEN_W-1:0] tag_rx_length,
  input  logic             tag_rx_done,
  output logic [TAG_W:0]   tags_inflight,
  output logic             err_cpl
`ifdef DMA_RD_TIMEOUT_EN
  ,
  output logic             err_timeout
`endif
);

  // One extra pointer bit distinguishes full (32) from empty (0).
  logic [TAG_W:0]   wr_ptr, rd_ptr;
  logic             alloc_go, free_en, cpl_err, force_cmpl;
  logic             head_valid, head_cmpl, head_last;
  logic [LEN_W-1:0] head_len;
  logic [TAG_W-1:0] head_idx;
  rel_state_t       state, state_nxt;

  assign tags_inflight = wr_ptr - rd_ptr;
  assign head_idx      = rd_ptr[TAG_W-1:0];
  assign alloc_go      = alloc_req & ~alloc_ack & ~tags_inflight[TAG_W];
  assign free_en       = (state == FREE);
  assign tag_rx_req    = (state == REQ);

  dma_tag_table u_table (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_go),
    .alloc_idx  (wr_ptr[TAG_W-1:0]),
    .alloc_len  (alloc_len),
    .alloc_last (alloc_last),
    .cpl_en     (cpl_valid),
    .cpl_idx    (cpl_tag),
    .cpl_dw     (cpl_dw),
    .cpl_err    (cpl_err),
    .free_en    (free_en),
    .free_idx   (head_idx),
    .force_cmpl (force_cmpl),
    .head_idx   (head_idx),
    .head_valid (head_valid),
    .head_cmpl  (head_cmpl),
    .head_last  (head_last),
    .head_len   (head_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ack <= 1'b0;
      alloc_tag <= '0;
      wr_ptr    <= '0;
      err_cpl   <= 1'b0;
    end else begin
      alloc_ack <= alloc_go;
      if (alloc_go) begin
        alloc_tag <= wr_ptr[TAG_W-1:0];
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (cpl_err) err_cpl <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (head_valid && head_cmpl) state_nxt = REQ;
      REQ:     if (tag_rx_ack) state_nxt = BUSY;
      BUSY:    if (tag_rx_done) state_nxt = FREE;
      FREE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      tag_rx_number <= '0;
      tag_rx_length <= '0;
      tag_rx_last   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (free_en) rd_ptr <= rd_ptr + 1'b1;
      // Fields are captured once so they stay stable through REQ and BUSY.
      if (state == IDLE && state_nxt == REQ) begin
        tag_rx_number <= head_idx;
        tag_rx_length <= head_len;
        tag_rx_last   <= head_last;
      end
    end
  end

`ifdef DMA_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            head_wait, head_cpl;

  assign head_wait  = head_valid & ~head_cmpl;
  assign head_cpl   = cpl_valid & (cpl_tag == head_idx);
  assign force_cmpl = head_wait & ~head_cpl & (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (free_en || !head_wait || head_cpl || force_cmpl) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      if (force_cmpl) err_timeout <= 1'b1;
    end
  end
`else
  assign force_cmpl = 1'b0;
`endif

endmodule
